// File: rtl/inv_gen_round_keys.sv
// AES-128 round-key generator that walks forward and backward through the schedule.
// Optional macro KEY_JUMP_EN adds one-edge jumps to round 0 (orig_key) and round 10 (last_key).
module inv_gen_round_keys (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         key_load,
   input  logic [127:0] rx_key,
   input  logic [3:0]   cur_round,
   output logic [127:0] cur_key,
   output logic [127:0] orig_key,
   output logic         key_ready,
   output logic         key_valid,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_e;

   state_e       state_q, state_d;
   logic [127:0] wk_q, wk_d;
   logic [127:0] orig_q, orig_d;
   logic [3:0]   wk_round_q, wk_round_d;
   logic [3:0]   exp_cnt_q, exp_cnt_d;
   logic         ready_q, ready_d;
`ifdef KEY_JUMP_EN
   logic [127:0] last_key_q, last_key_d;
`endif

   logic [3:0]   cr_s;
   logic         step_back_s;
   logic [3:0]   rc_idx_s;
   logic [31:0]  c0_s, c1_s, c2_s, c3_s;
   logic [31:0]  sw_in_s, sw_out_s;
   logic [127:0] fwd_key_s, bwd_key_s;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (a^254) followed by the AES affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] e;
      logic [7:0] b;
      r = 8'h01;
      e = 8'hfe;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         r = e[i] ? gf_mul(r, a) : r;
      end
      b = r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign cr_s = (cur_round > 4'd10) ? 4'd10 : cur_round;
   assign {c0_s, c1_s, c2_s, c3_s} = wk_q;

   // Single SubWord datapath shared by forward and backward steps.
   assign step_back_s = (state_q == READY) && (cr_s < wk_round_q);
   assign rc_idx_s    = step_back_s ? wk_round_q : (wk_round_q + 4'd1);
   assign sw_in_s     = step_back_s ? (c3_s ^ c2_s) : c3_s;
   assign sw_out_s    = sub_rot_word(sw_in_s) ^ {rcon(rc_idx_s), 24'h000000};

   always_comb begin
      logic [31:0] n0, n1, n2;
      n0 = c0_s ^ sw_out_s;
      n1 = c1_s ^ n0;
      n2 = c2_s ^ n1;
      fwd_key_s = {n0, n1, n2, c3_s ^ n2};
      bwd_key_s = {c0_s ^ sw_out_s, c1_s ^ c0_s, c2_s ^ c1_s, c3_s ^ c2_s};
   end

   // Next-state logic: key_load wins over any expansion or stepping.
   always_comb begin
      state_d    = state_q;
      wk_d       = wk_q;
      orig_d     = orig_q;
      wk_round_d = wk_round_q;
      exp_cnt_d  = exp_cnt_q;
      ready_d    = ready_q;
`ifdef KEY_JUMP_EN
      last_key_d = last_key_q;
`endif
      if (key_load) begin
         state_d    = EXPAND;
         wk_d       = rx_key;
         orig_d     = rx_key;
         wk_round_d = 4'd0;
         exp_cnt_d  = 4'd0;
         ready_d    = 1'b0;
      end else begin
         case (state_q)
            EXPAND: begin
               wk_d       = fwd_key_s;
               wk_round_d = wk_round_q + 4'd1;
               exp_cnt_d  = exp_cnt_q + 4'd1;
               if (exp_cnt_q == 4'd9) begin
                  state_d = READY;
                  ready_d = 1'b1;
`ifdef KEY_JUMP_EN
                  last_key_d = fwd_key_s;
`endif
               end else begin
                  state_d = EXPAND;
               end
            end
            READY: begin
`ifdef KEY_JUMP_EN
               if (cr_s != wk_round_q && cr_s == 4'd0) begin
                  wk_d       = orig_q;
                  wk_round_d = 4'd0;
               end else if (cr_s != wk_round_q && cr_s == 4'd10) begin
                  wk_d       = last_key_q;
                  wk_round_d = 4'd10;
               end else
`endif
               if (cr_s > wk_round_q) begin
                  wk_d       = fwd_key_s;
                  wk_round_d = wk_round_q + 4'd1;
               end else if (cr_s < wk_round_q) begin
                  wk_d       = bwd_key_s;
                  wk_round_d = wk_round_q - 4'd1;
               end else begin
                  wk_d = wk_q;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // State and key registers; reset clears everything and abandons expansion.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         wk_q       <= 128'h0;
         orig_q     <= 128'h0;
         wk_round_q <= 4'd0;
         exp_cnt_q  <= 4'd0;
         ready_q    <= 1'b0;
`ifdef KEY_JUMP_EN
         last_key_q <= 128'h0;
`endif
      end else begin
         state_q    <= state_d;
         wk_q       <= wk_d;
         orig_q     <= orig_d;
         wk_round_q <= wk_round_d;
         exp_cnt_q  <= exp_cnt_d;
         ready_q    <= ready_d;
`ifdef KEY_JUMP_EN
         last_key_q <= last_key_d;
`endif
      end
   end

   assign cur_key   = wk_q;
   assign orig_key  = orig_q;
   assign key_ready = ready_q;
   assign busy      = (state_q == EXPAND);
   assign key_valid = ready_q && (state_q == READY) && (wk_round_q == cr_s);

endmodule

// File: tb/tb_inv_gen_round_keys.sv
// Directed scoreboard bench for inv_gen_round_keys (default and KEY_JUMP_EN builds).
module tb_inv_gen_round_keys;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         key_load;
   logic [127:0] rx_key;
   logic [3:0]   cur_round;
   logic [127:0] cur_key;
   logic [127:0] orig_key;
   logic         key_ready;
   logic         key_valid;
   logic         busy;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string        tag;
      logic [127:0] val;
   } exp_t;
   exp_t sb[$];

   localparam logic [127:0] K1     = 128'h68656c6c6f3030303030303030303030;
   localparam logic [127:0] K1_R10 = 128'h0043de6459c9e24b5a4ebb8add080009;
   localparam logic [127:0] K1_R9  = 128'h6ca93273598a3c2f038759c18746bb83;
   localparam logic [127:0] K1_R1  = 128'h6d616868025158583261686802515858;
   localparam logic [127:0] K1_R2  = 128'hbe0b021fbc5a5a478e3b322f8c6a6a77;
   localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2_R9  = 128'hac7766f319fadc2128d12941575c006e;

   inv_gen_round_keys dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .key_load  (key_load),
      .rx_key    (rx_key),
      .cur_round (cur_round),
      .cur_key   (cur_key),
      .orig_key  (orig_key),
      .key_ready (key_ready),
      .key_valid (key_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [127:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL sb_empty: observed %h expected none", cur_key);
      end else begin
         e = sb.pop_front();
         chk(e.tag, cur_key, e.val);
      end
   endtask

   task automatic load_key(input logic [127:0] k);
      rx_key   = k;
      key_load = 1'b1;
      tick(1);
      key_load = 1'b0;
   endtask

   task automatic set_round(input logic [3:0] r, input string tag, input logic [127:0] exp);
      cur_round = r;
      push(tag, exp);
   endtask

   initial begin
      n_rst = 1'b0; key_load = 1'b0; rx_key = 128'h0; cur_round = 4'd10;
      #2;
      chk("rst_cur_key", cur_key, 128'h0);
      chk("rst_orig_key", orig_key, 128'h0);
      chk("rst_flags", {125'h0, key_ready, key_valid, busy}, 128'h0);
      tick(2);
      n_rst = 1'b1;
      tick(3);
      chk("idle_flags", {125'h0, key_ready, key_valid, busy}, 128'h0);

      // Expansion of K1
      push("exp_start", K1);
      load_key(K1);
      sb_check();
      chk("exp_orig", orig_key, K1);
      chk("exp_flags", {125'h0, key_ready, key_valid, busy}, 128'h1);
      tick(9);
      chk("exp_edge9_flags", {125'h0, key_ready, key_valid, busy}, 128'h1);
      push("exp_r10", K1_R10);
      tick(1);
      sb_check();
      chk("ready_flags", {125'h0, key_ready, key_valid, busy}, 128'h6);

      // Backward walk
      set_round(4'd9, "walk_r9", K1_R9);
      tick(1);
      sb_check();
      chk("walk_r9_valid", {127'h0, key_valid}, 128'h1);
      set_round(4'd1, "walk_r1", K1_R1);
      tick(7);
      chk("walk_r1_early_valid", {127'h0, key_valid}, 128'h0);
      tick(1);
      sb_check();
      chk("walk_r1_valid", {127'h0, key_valid}, 128'h1);
      set_round(4'd0, "walk_r0", K1);
      tick(1);
      sb_check();
      set_round(4'd2, "walk_r2", K1_R2);
      tick(1);
      chk("walk_r2_early_valid", {127'h0, key_valid}, 128'h0);
      tick(1);
      sb_check();

      // Clamp 15 -> 10, then full-range moves
      set_round(4'd15, "clamp_r10", K1_R10);
`ifdef KEY_JUMP_EN
      tick(1);
`else
      tick(8);
`endif
      sb_check();
      chk("clamp_valid", {127'h0, key_valid}, 128'h1);
      set_round(4'd0, "range_r0", K1);
`ifdef KEY_JUMP_EN
      tick(1);
`else
      tick(9);
      chk("range_r0_early_valid", {127'h0, key_valid}, 128'h0);
      tick(1);
`endif
      sb_check();
      set_round(4'd10, "range_r10", K1_R10);
`ifdef KEY_JUMP_EN
      tick(1);
`else
      tick(10);
`endif
      sb_check();
      chk("orig_stable", orig_key, K1);

      // Restart mid-expansion with K2 on the 5th EXPAND edge
      load_key(K1);
      tick(4);
      push("restart_start", K2);
      load_key(K2);
      sb_check();
      chk("restart_orig", orig_key, K2);
      tick(9);
      chk("restart_edge9_ready", {127'h0, key_ready}, 128'h0);
      push("restart_r10", K2_R10);
      tick(1);
      sb_check();
      chk("restart_ready", {127'h0, key_ready}, 128'h1);
      set_round(4'd9, "restart_r9", K2_R9);
      tick(1);
      sb_check();

      // Asynchronous reset mid-expansion
      load_key(K1);
      tick(4);
      n_rst = 1'b0;
      #1;
      chk("arst_cur_key", cur_key, 128'h0);
      chk("arst_orig_key", orig_key, 128'h0);
      chk("arst_flags", {125'h0, key_ready, key_valid, busy}, 128'h0);
      tick(1);
      n_rst = 1'b1;
      tick(15);
      chk("arst_idle_flags", {125'h0, key_ready, key_valid, busy}, 128'h0);
      chk("arst_idle_key", cur_key, 128'h0);

      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL sb_leftover: observed %0d expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/inv_gen_round_keys.md
INV_GEN_ROUND_KEYS -- requirements
Module: inv_gen_round_keys

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-low (ports clk, n_rst).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- n_rst  in  1  async active-low reset.
- key_load  in  1  one-cycle pulse; latches rx_key and starts expansion.
- rx_key  in  128  AES-128 cipher key; word w0 = [127:96].
- cur_round  in  4  requested round index 0..10; values 11..15 are treated as 10.
- cur_key  out  128  working round key (registered).
- orig_key  out  128  latched cipher key (round 0).
- key_ready  out  1  high once the expansion has completed.
- key_valid  out  1  combinational; key_ready && (wk_round == clamped cur_round).
- busy  out  1  high while in EXPAND.

Function
REQ-003 SHALL hold the registers state {IDLE, EXPAND, READY}, wk (128, drives cur_key), wk_round (4) and exp_cnt (4).
REQ-004 SHALL, when key_load is high at a clock edge in any state, load orig_key and wk from rx_key, set wk_round=0 and exp_cnt=0, clear key_ready, and enter EXPAND.
REQ-005 SHALL, in EXPAND, advance wk one round forward per edge using the standard schedule with Rcon[wk_round+1] (Rcon = 01,02,04,08,10,20,40,80,1b,36).
REQ-006 SHALL enter READY with wk_round=10 on the 10th EXPAND edge, setting key_ready; key_ready is visible 10 edges after the key_load edge.
REQ-007 SHALL, in READY, move wk one round per edge toward the clamped cur_round when the two differ, and hold wk when they are equal.
REQ-008 SHALL, when stepping backward from round r with current words c0..c3, produce p3=c3^c2, p2=c2^c1, p1=c1^c0, p0=c0^SubWord(RotWord(p3))^Rcon[r].
REQ-009 SHALL share one 4-S-box SubWord path between the two directions: its input is c3 forward and c3^c2 backward.
REQ-010 SHALL give key_load priority over stepping; key_load during EXPAND restarts the expansion from the new rx_key.
REQ-011 SHALL ignore cur_round in IDLE and EXPAND; key_valid SHALL be 0 in those states.
REQ-012 SHALL ensure that a change of cur_round by d rounds yields key_valid exactly d edges later, provided cur_round is held stable and key_load stays low.
REQ-013 SHALL never move wk_round outside 0..10.
REQ-014 SHALL keep orig_key constant from one key_load to the next.

Reset
REQ-015 SHALL, on n_rst low, immediately set state=IDLE, wk=0, wk_round=0, exp_cnt=0, orig_key=0, cur_key=0, key_ready=0, key_valid=0 and busy=0.
REQ-016 SHALL abandon any expansion interrupted by reset; after release the block stays in IDLE until key_load.

Configuration
REQ-017 SHALL support the macro KEY_JUMP_EN as follows:
- Defined: a 128-bit last_key register captures the round-10 key at the end of EXPAND. In READY, a clamped cur_round of 0 loads orig_key, and 10 loads last_key, in one edge, with wk_round set to match.
- Undefined: last_key is absent and every transition steps one round per edge.

Verification
REQ-018 Reset then key_load with rx_key=68656c6c6f3030303030303030303030 -> busy high for 10 edges; key_ready high after edge 10; cur_key=0043de6459c9e24b5a4ebb8add080009; orig_key=rx_key.
REQ-019 In READY, cur_round 10->9 -> after 1 edge cur_key=6ca93273598a3c2f038759c18746bb83 and key_valid=1; then cur_round=1 -> after 8 edges cur_key=6d616868025158583261686802515858.
REQ-020 cur_round=0 from round 1 -> cur_key=rx_key after 1 edge; cur_round=2 -> be0b021fbc5a5a478e3b322f8c6a6a77 after 2 edges.
REQ-021 key_load asserted on the 5th EXPAND edge with a new key -> expansion restarts; key_ready rises 10 edges after the second load; the round-10 key matches the new key.
REQ-022 n_rst pulsed low mid-EXPAND -> all outputs 0 at once; state IDLE; no key_ready without a new key_load.
REQ-023 cur_round=15 in READY -> treated as 10; with KEY_JUMP_EN and cur_round 0->10, cur_key=0043de64...0009 after 1 edge (10 edges without the macro).
